a_path_deskew: RTL and testbench
================================

A_PATH_DESKEW -- requirements
Module: a_path_deskew

Interface
REQ-001 SHALL have parameter SIZE, default 3: number of lanes (matrix dimension), SIZE >= 2.
REQ-002 SHALL have parameter DATA_SIZE, default 16: bits per lane.
REQ-003 SHALL have one clock and an asynchronous, active-low reset (the port list below fixes the names).
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: a_in  input  DATA_SIZE*SIZE  skewed lane bus; lane k = bits [DATA_SIZE*(SIZE-k)-1 -: DATA_SIZE], lane 0 in the MSBs.
REQ-007 Port: reset_counter  input  1  rotation-counter restart request.
REQ-008 Port: reverted_a  output  DATA_SIZE*SIZE  de-skewed bus (revert-stage output).
REQ-009 Port: reset_counter_dly  output  1  reset_counter delayed SIZE cycles.
REQ-010 Port: a_out  output  DATA_SIZE*SIZE  de-skewed, delayed, lane-rotated bus; same lane packing as a_in.

Function
REQ-011 Revert stage: reverted_a lane k SHALL equal a_in lane k delayed by exactly SIZE-k clock edges (lane 0: SIZE, lane SIZE-1: 1).
REQ-012 The revert stage SHALL be a per-lane register shift chain; data SHALL pass unmodified.
REQ-013 Bus delay stage: the stage SHALL register reverted_a for exactly 1 edge, producing dly_a.
REQ-014 Control delay: reset_counter_dly SHALL equal reset_counter delayed exactly SIZE edges through a SIZE-deep shift register.
REQ-015 Transformer counter: cnt SHALL be ceil(log2(SIZE)) bits wide (minimum 1) and SHALL hold a value in 0..SIZE-1.
REQ-016 Each edge, sel = 0 when reset_counter_dly=1, else (cnt+1) mod SIZE; cnt SHALL load sel.
REQ-017 Each edge, a_out lane i SHALL load dly_a lane ((i+sel) mod SIZE), for every i.
REQ-018 When reset_counter_dly=1 on an edge, the counter restart SHALL take priority over the increment.
REQ-019 Counter wrap SHALL be SIZE-1 -> 0 without glitching or skipping a value.
REQ-020 End-to-end latency of a_in lane k to a_out SHALL be SIZE-k+2 edges; its output lane position SHALL be set by sel at the output edge.
REQ-021 The block SHALL apply no arithmetic to data; it SHALL have no valid/ready handshake, and data SHALL be accepted every cycle.

Reset
REQ-022 When rst_n=0, the block SHALL immediately clear all shift registers, dly_a, a_out, reverted_a, reset_counter_dly and cnt to 0, independent of clk.
REQ-023 After rst_n deasserts, operation SHALL resume on the next rising edge with cnt=0.
REQ-024 Reset asserted mid-stream SHALL discard all in-flight data, and outputs SHALL read 0 until new data propagates through the stages.

Verification (SIZE=3, DATA_SIZE=16)
REQ-025 Reset, then hold a_in={0x0100,0x0200,0x0300} and reset_counter=1 -> reverted_a lane2=0x0300 after 1 edge, lane0=0x0100 after 3 edges; a_out={0x0100,0x0200,0x0300} from edge 5 onward.
REQ-026 Reset, same a_in, reset_counter=0 -> a_out at edge 5 = {0x0300,0x0100,0x0200}, edge 6 = {0x0100,0x0200,0x0300}, edge 7 = {0x0200,0x0300,0x0100}, repeating with period 3.
REQ-027 Single-cycle reset_counter=1 pulse at edge t -> reset_counter_dly high only at edge t+3; at that edge sel=0 and a_out is unrotated, then sel=1,2,0,...
REQ-028 Single-cycle a_in pulse {0x0A00,0x0B00,0x0C00} then zeros -> 0x0C00 appears on a_out at edge 3, 0x0B00 at edge 4, 0x0A00 at edge 5, each one cycle wide.
REQ-029 Assert rst_n=0 between clock edges during streaming -> all outputs read 0 before the next edge; cnt=0 after release.

Source files
------------

// File: rtl/a_path_deskew_if.sv
// Lane bus of the A-path deskew block: skewed input plus reverted and rotated outputs.
interface a_path_deskew_if #(
    parameter int unsigned SIZE      = 3,
    parameter int unsigned DATA_SIZE = 16
);
    logic [DATA_SIZE*SIZE-1:0] a_in;
    logic                      reset_counter;
    logic [DATA_SIZE*SIZE-1:0] reverted_a;
    logic                      reset_counter_dly;
    logic [DATA_SIZE*SIZE-1:0] a_out;

    // Driver side (producer of skewed data, consumer of results).
    modport master (
        output a_in,
        output reset_counter,
        input  reverted_a,
        input  reset_counter_dly,
        input  a_out
    );

    // Deskew block side.
    modport slave (
        input  a_in,
        input  reset_counter,
        output reverted_a,
        output reset_counter_dly,
        output a_out
    );
endinterface

// File: rtl/a_path_deskew.sv
// A-path deskew: undoes the per-lane skew of a systolic input bus, delays it one stage,
// then rotates the lanes by a free-running counter that can be restarted by reset_counter.
module a_path_deskew #(
    parameter int unsigned SIZE      = 3,
    parameter int unsigned DATA_SIZE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    a_path_deskew_if.slave   bus
);

    // SIZE >= 2, so this is always at least 1 bit and also wide enough to index a lane.
    localparam int unsigned CNT_W = $clog2(SIZE);

    typedef logic [DATA_SIZE-1:0] lane_t;

    lane_t                     in_lane  [SIZE];
    lane_t                     rev_lane [SIZE];
    lane_t                     dly_q    [SIZE];
    lane_t                     out_q    [SIZE];
    lane_t                     out_d    [SIZE];
    logic [SIZE-1:0]           rc_sr_q;
    logic                      rc_dly;
    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          sel;
    logic [CNT_W-1:0]          src_idx;
    logic [DATA_SIZE*SIZE-1:0] rev_bus;
    logic [DATA_SIZE*SIZE-1:0] out_bus;

    // Unpack the skewed bus; lane 0 sits in the MSBs.
    always_comb begin
        for (int k = 0; k < SIZE; k++) begin
            in_lane[k] = bus.a_in[DATA_SIZE*(SIZE-k)-1 -: DATA_SIZE];
        end
    end

    // Lane k waits SIZE-k edges so all lanes of one vector line up at the chain outputs.
    for (genvar k = 0; k < SIZE; k++) begin : g_revert
        localparam int unsigned DEPTH = SIZE - k;
        lane_t sr_q [DEPTH];

        // Per-lane shift chain.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j < DEPTH; j++) sr_q[j] <= '0;
            end else begin
                sr_q[0] <= in_lane[k];
                for (int j = 1; j < DEPTH; j++) sr_q[j] <= sr_q[j-1];
            end
        end

        assign rev_lane[k] = sr_q[DEPTH-1];
    end

    // One-stage bus delay and reset_counter delay line, matched to the revert depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SIZE; i++) dly_q[i] <= '0;
            rc_sr_q <= '0;
        end else begin
            for (int i = 0; i < SIZE; i++) dly_q[i] <= rev_lane[i];
            rc_sr_q <= {rc_sr_q[SIZE-2:0], bus.reset_counter};
        end
    end

    assign rc_dly = rc_sr_q[SIZE-1];

    // Next rotation amount: restart wins over increment, wrap at SIZE-1.
    always_comb begin
        sel = '0;
        if (!rc_dly && (cnt_q != CNT_W'(SIZE - 1))) begin
            sel = cnt_q + CNT_W'(1);
        end
    end

    // Output lane i takes delayed lane (i + sel) mod SIZE.
    always_comb begin
        src_idx = '0;
        for (int i = 0; i < SIZE; i++) begin
            src_idx  = CNT_W'((i + int'(sel)) % SIZE);
            out_d[i] = dly_q[src_idx];
        end
    end

    // Rotation counter and rotated output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            for (int i = 0; i < SIZE; i++) out_q[i] <= '0;
        end else begin
            cnt_q <= sel;
            for (int i = 0; i < SIZE; i++) out_q[i] <= out_d[i];
        end
    end

    // Repack lanes onto the output buses, lane 0 in the MSBs.
    always_comb begin
        rev_bus = '0;
        out_bus = '0;
        for (int k = 0; k < SIZE; k++) begin
            rev_bus[DATA_SIZE*(SIZE-k)-1 -: DATA_SIZE] = rev_lane[k];
            out_bus[DATA_SIZE*(SIZE-k)-1 -: DATA_SIZE] = out_q[k];
        end
    end

    assign bus.reverted_a        = rev_bus;
    assign bus.a_out             = out_bus;
    assign bus.reset_counter_dly = rc_dly;

endmodule

// File: tb/tb_a_path_deskew.sv
// Directed bench for a_path_deskew (SIZE=3, DATA_SIZE=16) with a queue-based scoreboard.
module tb_a_path_deskew;

    localparam int SIZE = 3;
    localparam int DW   = 16;
    localparam int W    = DW * SIZE;
    localparam int MAXN = 10;

    logic clk = 1'b0;
    logic rst_n;

    a_path_deskew_if #(.SIZE(SIZE), .DATA_SIZE(DW)) bus ();

    a_path_deskew #(.SIZE(SIZE), .DATA_SIZE(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] a_out;
        logic [W-1:0] rev;
        logic         rcd;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   total = 0;
    int   bad   = 0;

    // Per-edge stimulus and hand-computed expected values after that edge.
    logic [W-1:0] t_ain [MAXN];
    logic         t_rc  [MAXN];
    logic [W-1:0] t_rev [MAXN];
    logic         t_rcd [MAXN];
    logic [W-1:0] t_out [MAXN];

    function automatic logic [W-1:0] pk(input logic [DW-1:0] l0, input logic [DW-1:0] l1,
                                        input logic [DW-1:0] l2);
        return {l0, l1, l2};
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: one scoreboard entry per clock edge, sampled 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            chk({cur.name, ".a_out"}, bus.a_out, cur.a_out);
            chk({cur.name, ".reverted_a"}, bus.reverted_a, cur.rev);
            chk({cur.name, ".rc_dly"}, W'(bus.reset_counter_dly), W'(cur.rcd));
        end
    end

    task automatic set_row(input int i, input logic [W-1:0] ain, input logic rc,
                           input logic [W-1:0] rev, input logic rcd, input logic [W-1:0] out);
        t_ain[i] = ain;
        t_rc[i]  = rc;
        t_rev[i] = rev;
        t_rcd[i] = rcd;
        t_out[i] = out;
    endtask

    // Called at a negedge; drives each row, queues its expectation, ends at a negedge.
    task automatic run_tbl(input string name, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            bus.a_in          = t_ain[i];
            bus.reset_counter = t_rc[i];
            e.name  = $sformatf("%s.e%0d", name, i + 1);
            e.a_out = t_out[i];
            e.rev   = t_rev[i];
            e.rcd   = t_rcd[i];
            sb.push_back(e);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check_zero(input string name);
        chk({name, ".a_out"}, bus.a_out, '0);
        chk({name, ".reverted_a"}, bus.reverted_a, '0);
        chk({name, ".rc_dly"}, W'(bus.reset_counter_dly), '0);
    endtask

    // Called at a negedge; pulses reset for one cycle and returns at a negedge.
    task automatic do_reset(input string name);
        rst_n             = 1'b0;
        bus.a_in          = '0;
        bus.reset_counter = 1'b0;
        #1;
        check_zero(name);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [W-1:0] p, z, r1, r2;

    task automatic load_free_run();
        set_row(0, p, 1'b0, r1, 1'b0, z);
        set_row(1, p, 1'b0, r2, 1'b0, z);
        set_row(2, p, 1'b0, p,  1'b0, r1);
        set_row(3, p, 1'b0, p,  1'b0, pk(16'h0200, 16'h0300, 16'h0000));
        set_row(4, p, 1'b0, p,  1'b0, pk(16'h0300, 16'h0100, 16'h0200));
        set_row(5, p, 1'b0, p,  1'b0, p);
        set_row(6, p, 1'b0, p,  1'b0, pk(16'h0200, 16'h0300, 16'h0100));
        set_row(7, p, 1'b0, p,  1'b0, pk(16'h0300, 16'h0100, 16'h0200));
        set_row(8, p, 1'b0, p,  1'b0, p);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        p  = pk(16'h0100, 16'h0200, 16'h0300);
        z  = '0;
        r1 = pk(16'h0000, 16'h0000, 16'h0300);
        r2 = pk(16'h0000, 16'h0200, 16'h0300);

        rst_n             = 1'b0;
        bus.a_in          = '0;
        bus.reset_counter = 1'b0;
        #1;
        check_zero("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // reset_counter held high: output settles unrotated from edge 5.
        set_row(0, p, 1'b1, r1, 1'b0, z);
        set_row(1, p, 1'b1, r2, 1'b0, z);
        set_row(2, p, 1'b1, p,  1'b1, r1);
        set_row(3, p, 1'b1, p,  1'b1, r2);
        set_row(4, p, 1'b1, p,  1'b1, p);
        set_row(5, p, 1'b1, p,  1'b1, p);
        set_row(6, p, 1'b1, p,  1'b1, p);
        run_tbl("hold_rc", 7);

        // Free-running rotation, period 3.
        do_reset("rst_b");
        load_free_run();
        run_tbl("free_run", 9);

        // Single-vector pulse: lane 2 first, lane 0 last, each one cycle wide.
        do_reset("rst_c");
        set_row(0, pk(16'h0A00, 16'h0B00, 16'h0C00), 1'b0, pk(16'h0000, 16'h0000, 16'h0C00),
                1'b0, z);
        set_row(1, z, 1'b0, pk(16'h0000, 16'h0B00, 16'h0000), 1'b0, z);
        set_row(2, z, 1'b0, pk(16'h0A00, 16'h0000, 16'h0000), 1'b0,
                pk(16'h0000, 16'h0000, 16'h0C00));
        set_row(3, z, 1'b0, z, 1'b0, pk(16'h0B00, 16'h0000, 16'h0000));
        set_row(4, z, 1'b0, z, 1'b0, pk(16'h0000, 16'h0A00, 16'h0000));
        set_row(5, z, 1'b0, z, 1'b0, z);
        run_tbl("pulse", 6);

        // reset_counter sampled at edge 4 forces sel=0 at edge 7 (would otherwise be 1).
        do_reset("rst_d");
        load_free_run();
        set_row(3, p, 1'b1, p, 1'b0, pk(16'h0200, 16'h0300, 16'h0000));
        set_row(5, p, 1'b0, p, 1'b1, p);
        set_row(6, p, 1'b0, p, 1'b0, p);
        set_row(7, p, 1'b0, p, 1'b0, pk(16'h0200, 16'h0300, 16'h0100));
        set_row(8, p, 1'b0, p, 1'b0, pk(16'h0300, 16'h0100, 16'h0200));
        set_row(9, p, 1'b0, p, 1'b0, p);
        run_tbl("rc_pulse", 10);

        // Asynchronous reset mid-stream, between clock edges.
        do_reset("rst_e");
        load_free_run();
        run_tbl("pre_async", 5);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        check_zero("async_hold");
        rst_n = 1'b1;
        load_free_run();
        run_tbl("post_async", 9);

        @(posedge clk);
        @(negedge clk);
        chk("sb_drain", W'(sb.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
